hier_path_decoder: RTL and testbench

Receiving end of the hierarchy-path link. The path encoder walks the instance tree and emits one selector digit per level, root level first. This block reassembles those digits into a full packed path and flags malformed paths. Its output drives the instance-select logic of the generated module tree.

---
 rtl/hier_path_pkg.sv | 18 +
 rtl/hier_path_decoder.sv | 113 +++++++++++
 tb/tb_hier_path_decoder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hier_path_pkg.sv
// Shared definitions for the hierarchy-path decoder.
// Holds the default geometry of the instance tree, the decoder state encoding
// and the packed path type at default geometry.
package hier_path_pkg;

  localparam int unsigned LEVELS_DEF  = 10;
  localparam int unsigned FANOUT_DEF  = 5;
  localparam int unsigned DIGIT_W_DEF = 3;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } state_t;

  typedef logic [LEVELS_DEF*DIGIT_W_DEF-1:0] path_t;

endpackage

// File: rtl/hier_path_decoder.sv
// Reassembles per-level selector digits (root level first) into a packed
// hierarchy path and flags illegal digits or over-deep paths.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     digit beat handshake
//   s_data              selector digit for the current level
//   s_last              final digit of the path
//   m_valid/m_ready     decoded path handshake
//   m_path              level i at bits [i*DIGIT_W +: DIGIT_W], unused levels 0
//   m_depth             digits received (1..LEVELS), LEVELS on overflow
//   m_error             illegal digit seen or path deeper than LEVELS
module hier_path_decoder
  import hier_path_pkg::*;
#(
  parameter int unsigned LEVELS  = LEVELS_DEF,
  parameter int unsigned FANOUT  = FANOUT_DEF,
  parameter int unsigned DIGIT_W = DIGIT_W_DEF,
  parameter int unsigned DEPTH_W = $clog2(LEVELS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DIGIT_W-1:0]          s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [LEVELS*DIGIT_W-1:0]   m_path,
  output logic [DEPTH_W-1:0]          m_depth,
  output logic                        m_error
);

  localparam int unsigned PATH_W = LEVELS * DIGIT_W;

  state_t              state_q, state_d;
  logic [PATH_W-1:0]   path_q,  path_d;
  logic [DEPTH_W-1:0]  cnt_q,   cnt_d;
  logic                err_q,   err_d;
  logic                digit_bad;

  // Widened compare so FANOUT == 2**DIGIT_W does not wrap to zero.
  assign digit_bad = ({1'b0, s_data} >= (DIGIT_W+1)'(FANOUT));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      path_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      path_q  <= path_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    path_d  = path_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      COLLECT: begin
        if (s_valid) begin
          // cnt_q is always < LEVELS here, so exactly one slot matches.
          for (int i = 0; i < int'(LEVELS); i++) begin
            if (cnt_q == DEPTH_W'(i)) begin
              path_d[i*DIGIT_W +: DIGIT_W] = s_data;
            end
          end
          cnt_d = cnt_q + DEPTH_W'(1);
          if (digit_bad) begin
            err_d = 1'b1;
          end
          if (s_last) begin
            state_d = HOLD;
          end else if (cnt_q == DEPTH_W'(LEVELS - 1)) begin
            err_d   = 1'b1;
            state_d = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (s_valid && s_last) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (m_ready) begin
          state_d = COLLECT;
          path_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // Outputs come straight from registers or the decoded state.
  assign s_ready = (state_q != HOLD);
  assign m_valid = (state_q == HOLD);
  assign m_path  = path_q;
  assign m_depth = cnt_q;
  assign m_error = err_q;

endmodule

// File: tb/tb_hier_path_decoder.sv
// Directed self-checking bench for hier_path_decoder.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a cycle away from the active rising edge.
module tb_hier_path_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [2:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [29:0] m_path;
  logic [3:0]  m_depth;
  logic        m_error;

  int checks = 0;
  int errors = 0;

  hier_path_decoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_path  (m_path),
    .m_depth (m_depth),
    .m_error (m_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [29:0] p,
                           input logic [3:0] d, input logic e);
    check({tag, " m_valid"}, 32'(m_valid), 32'(v));
    check({tag, " m_path"},  32'(m_path),  32'(p));
    check({tag, " m_depth"}, 32'(m_depth), 32'(d));
    check({tag, " m_error"}, 32'(m_error), 32'(e));
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_data  = 3'd0;
    s_last  = 1'b0;
  endtask

  // Present one beat at a falling edge; it is accepted on the next rising edge.
  task automatic beat(input string tag, input logic [2:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    #1;
    check({tag, " s_ready"}, 32'(s_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] ovf_digits [12];
    rst_n   = 1'b0;
    m_ready = 1'b1;
    idle();

    // Reset state
    @(negedge clk);
    check("reset s_ready", 32'(s_ready), 32'd1);
    check_out("reset", 1'b0, 30'o0, 4'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-depth legal path, s_last on 10th beat
    beat("full", 3'd0, 1'b0); beat("full", 3'd0, 1'b0);
    beat("full", 3'd0, 1'b0); beat("full", 3'd0, 1'b0);
    beat("full", 3'd0, 1'b0); beat("full", 3'd0, 1'b0);
    beat("full", 3'd2, 1'b0); beat("full", 3'd2, 1'b0);
    beat("full", 3'd0, 1'b0); beat("full", 3'd3, 1'b1);
    idle();
    check_out("full", 1'b1, 30'o3022000000, 4'd10, 1'b0);
    check("full s_ready in hold", 32'(s_ready), 32'd0);
    @(negedge clk);
    check_out("full after handshake", 1'b0, 30'o0, 4'd0, 1'b0);

    // Short path
    beat("short", 3'd4, 1'b0); beat("short", 3'd1, 1'b0); beat("short", 3'd2, 1'b1);
    idle();
    check_out("short", 1'b1, 30'o214, 4'd3, 1'b0);
    @(negedge clk);

    // Illegal digit
    beat("illegal", 3'd1, 1'b0); beat("illegal", 3'd7, 1'b0); beat("illegal", 3'd0, 1'b1);
    idle();
    check_out("illegal", 1'b1, 30'o071, 4'd3, 1'b1);
    check("illegal level1", 32'(m_path[5:3]), 32'd7);
    @(negedge clk);

    // Boundary digit FANOUT-1 = 4 is legal; FANOUT = 5 is not
    beat("edge4", 3'd4, 1'b1);
    idle();
    check_out("edge4 single beat", 1'b1, 30'o4, 4'd1, 1'b0);
    @(negedge clk);
    beat("edge5", 3'd5, 1'b1);
    idle();
    check_out("edge5", 1'b1, 30'o5, 4'd1, 1'b1);
    @(negedge clk);

    // Overflow: 12 beats, s_last only on the 12th
    ovf_digits = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd1};
    for (int i = 0; i < 12; i++) begin
      beat("overflow", ovf_digits[i], (i == 11));
    end
    idle();
    check_out("overflow", 1'b1, 30'o4321043210, 4'd10, 1'b1);
    @(negedge clk);

    // Illegal digit plus overflow
    for (int i = 0; i < 11; i++) begin
      beat("ill+ovf", (i == 3) ? 3'd6 : 3'd1, (i == 10));
    end
    idle();
    check_out("ill+ovf", 1'b1, 30'o1111116111, 4'd10, 1'b1);
    @(negedge clk);

    // Backpressure with next path waiting on s_valid
    m_ready = 1'b0;
    beat("bp", 3'd3, 1'b0); beat("bp", 3'd3, 1'b1);
    s_valid = 1'b1; s_data = 3'd1; s_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp s_ready", 32'(s_ready), 32'd0);
      check_out("bp hold", 1'b1, 30'o33, 4'd2, 1'b0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check("bp released", 32'(m_valid), 32'd0);
    beat("bp next", 3'd1, 1'b0); beat("bp next", 3'd2, 1'b1);
    idle();
    check_out("bp next", 1'b1, 30'o21, 4'd2, 1'b0);
    @(negedge clk);

    // Reset mid-path, then a fresh 2-beat path
    beat("rst part", 3'd1, 1'b0); beat("rst part", 3'd2, 1'b0);
    beat("rst part", 3'd3, 1'b0); beat("rst part", 3'd4, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    check("mid-reset s_ready", 32'(s_ready), 32'd1);
    check_out("mid-reset", 1'b0, 30'o0, 4'd0, 1'b0);
    @(negedge clk);
    check_out("mid-reset held", 1'b0, 30'o0, 4'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    beat("fresh", 3'd0, 1'b0); beat("fresh", 3'd3, 1'b1);
    idle();
    check_out("fresh", 1'b1, 30'o30, 4'd2, 1'b0);
    @(negedge clk);
    check("fresh consumed", 32'(m_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
